// File: rtl/heap_arbiter_if.sv
// Request/response bus between two requesters and the heap arbiter.
// The requester side drives the request fields; the arbiter drives ready and the response.
interface heap_arbiter_if #(
    parameter int MemoryElementWidth = 12
);
    logic [1:0]                      reqValid;
    logic [3:0]                      reqOp;
    logic [2*MemoryElementWidth-1:0] reqArray;
    logic [2*MemoryElementWidth-1:0] reqData;
    logic [1:0]                      reqReady;
    logic [1:0]                      respValid;
    logic [MemoryElementWidth-1:0]   respData;
    logic                            respError;

    modport master (
        output reqValid, reqOp, reqArray, reqData,
        input  reqReady, respValid, respData, respError
    );

    modport slave (
        input  reqValid, reqOp, reqArray, reqData,
        output reqReady, respValid, respData, respError
    );
endinterface

// File: rtl/heap_arbiter.sv
// Two-requester round-robin arbiter in front of a small array heap.
// Supports ALLOC/FREE/PUSH/POP, with one operation in flight at a time.
module heap_arbiter #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 3,
    parameter int NArrays            = 4
) (
    input logic           clock,
    input logic           reset,
    heap_arbiter_if.slave bus
);
    localparam int W     = MemoryElementWidth;
    localparam int Depth = NArrays * NArea;
    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int IdW   = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int CntW  = $clog2(NArrays + 1);

    localparam logic [1:0] OpAlloc = 2'd0;
    localparam logic [1:0] OpFree  = 2'd1;
    localparam logic [1:0] OpPush  = 2'd2;
    localparam logic [1:0] OpPop   = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, nextState;

    logic [W-1:0]       heap       [Depth];
    logic [W-1:0]       sizes      [NArrays];
    logic [W-1:0]       freedStack [NArrays];
    logic [NArrays-1:0] allocated;
    logic [CntW-1:0]    freedCount;
    logic [W-1:0]       allocs;

    logic         lastGrant, grantIdx, ownerReg, acceptFire;
    logic [1:0]   opReg;
    logic [W-1:0] idReg, dataReg;
    logic [1:0]   readyC, respValidC;
    logic [W-1:0] respDataReg;
    logic         respErrorReg;

    logic [IdW-1:0]   idIdx, allocIdx;
    logic             idValid;
    logic [W-1:0]     curSize, allocId, execData;
    logic             execError;
    logic [AddrW-1:0] baseAddr, pushAddr, popAddr;
    logic             doAlloc, allocFromStack, doFree, doPush, doPop;

    // A lone requester always wins; under contention the one not served last time wins.
    always_comb begin
        grantIdx = 1'b0;
        case (bus.reqValid)
            2'b10:   grantIdx = 1'b1;
            2'b11:   grantIdx = ~lastGrant;
            default: grantIdx = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        readyC     = '0;
        respValidC = '0;
        acceptFire = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.reqValid) begin
                    readyC[grantIdx] = 1'b1;
                    acceptFire       = 1'b1;
                    nextState        = EXEC;
                end
            end
            EXEC: nextState = RESP;
            RESP: begin
                respValidC[ownerReg] = 1'b1;
                nextState            = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (reset) begin
            readyC     = '0;
            respValidC = '0;
            acceptFire = 1'b0;
        end
    end

    assign idIdx    = IdW'(idReg);
    assign curSize  = sizes[idIdx];
    assign idValid  = (idReg < W'(NArrays)) && allocated[idIdx];
    assign baseAddr = AddrW'(idIdx) * AddrW'(NArea);
    assign pushAddr = baseAddr + AddrW'(curSize);
    assign popAddr  = baseAddr + AddrW'(curSize - W'(1));
    assign allocIdx = IdW'(allocId);

    // Decide the outcome of the latched operation; nothing is committed unless it succeeds.
    always_comb begin
        execError      = 1'b0;
        execData       = '0;
        allocId        = '0;
        doAlloc        = 1'b0;
        allocFromStack = 1'b0;
        doFree         = 1'b0;
        doPush         = 1'b0;
        doPop          = 1'b0;
        case (opReg)
            OpAlloc: begin
                if (freedCount != '0) begin
                    allocId        = freedStack[IdW'(freedCount - CntW'(1))];
                    allocFromStack = 1'b1;
                    doAlloc        = 1'b1;
                    execData       = allocId;
                end else if (allocs >= W'(NArrays)) begin
                    execError = 1'b1;
                end else begin
                    allocId  = allocs;
                    doAlloc  = 1'b1;
                    execData = allocId;
                end
            end
            OpFree: begin
                if (!idValid) begin
                    execError = 1'b1;
                end else begin
                    doFree = 1'b1;
                end
            end
            OpPush: begin
                if (!idValid || curSize == W'(NArea)) begin
                    execError = 1'b1;
                end else begin
                    doPush   = 1'b1;
                    execData = curSize + W'(1);
                end
            end
            default: begin
                if (!idValid || curSize == '0) begin
                    execError = 1'b1;
                end else begin
                    doPop    = 1'b1;
                    execData = heap[popAddr];
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant    <= 1'b1;
            ownerReg     <= 1'b0;
            opReg        <= OpAlloc;
            idReg        <= '0;
            dataReg      <= '0;
            allocs       <= '0;
            freedCount   <= '0;
            allocated    <= '0;
            respDataReg  <= '0;
            respErrorReg <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                sizes[i] <= '0;
            end
        end else begin
            if (acceptFire) begin
                ownerReg  <= grantIdx;
                lastGrant <= grantIdx;
                opReg     <= grantIdx ? bus.reqOp[3:2] : bus.reqOp[1:0];
                idReg     <= grantIdx ? bus.reqArray[2*W-1:W] : bus.reqArray[W-1:0];
                dataReg   <= grantIdx ? bus.reqData[2*W-1:W] : bus.reqData[W-1:0];
            end
            if (state == EXEC) begin
                respDataReg  <= execData;
                respErrorReg <= execError;
                if (doAlloc) begin
                    if (allocFromStack) begin
                        freedCount <= freedCount - CntW'(1);
                    end else begin
                        allocs <= allocs + W'(1);
                    end
                    sizes[allocIdx]     <= '0;
                    allocated[allocIdx] <= 1'b1;
                end
                if (doFree) begin
                    freedCount       <= freedCount + CntW'(1);
                    sizes[idIdx]     <= '0;
                    allocated[idIdx] <= 1'b0;
                end
                if (doPush) begin
                    sizes[idIdx] <= curSize + W'(1);
                end
                if (doPop) begin
                    sizes[idIdx] <= curSize - W'(1);
                end
            end
        end
    end

    // Heap data and the freed-id stack need no reset; they are only read once validated.
    always_ff @(posedge clock) begin
        if (!reset && state == EXEC) begin
            if (doPush) begin
                heap[pushAddr] <= dataReg;
            end
            if (doFree) begin
                freedStack[IdW'(freedCount)] <= idReg;
            end
        end
    end

    assign bus.reqReady  = readyC;
    assign bus.respValid = respValidC;
    assign bus.respData  = respDataReg;
    assign bus.respError = respErrorReg;
endmodule
